vram_scan_arbiter: RTL

- Shares one single-port synchronous framebuffer RAM between VGA scan-out and a game-logic writer.
- Consumes the x/y/valid/pixclk/hsync/vsync outputs of the VGA timing generator.
- Issues display reads at upscaled framebuffer coordinates and returns the pixel with delay-matched syncs.
- Grants the writer every RAM cycle not needed by scan-out.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vram_delay_line.sv | 26 ++
 rtl/vram_scan_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer constants, slot encoding and scan address helper
// used by the framebuffer arbiter and its helpers.
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H        = V_ACTIVE >> SCALE_SHIFT;
  localparam int PIX_W       = 8;
  localparam int ADDR_W      = 15;
  localparam int FB_SIZE     = FB_W * FB_H;

  typedef enum logic [1:0] {IDLE, DISP, WR} slot_t;

  // Upscaled screen coordinate to linear framebuffer address.
  function automatic logic [ADDR_W-1:0] scan_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y >> SCALE_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(x >> SCALE_SHIFT);
  endfunction

endpackage

// File: rtl/vram_delay_line.sv
// Width/depth parameterised shift register with a configurable reset value.
module vram_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vram_scan_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scan-out and a writer.
// Define VRAM_DOUBLE_BUFFER_EN for a bank-swapped (double buffered) framebuffer.
module vram_scan_arbiter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              valid,
  input  logic              pixclk,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
`ifdef VRAM_DOUBLE_BUFFER_EN
  input  logic              swap_req,
  output logic              front_bank,
  output logic [ADDR_W:0]   ram_addr,
`else
  output logic [ADDR_W-1:0] ram_addr,
`endif
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_SIZE);

  slot_t                     slot;
  logic [$bits(ram_addr)-1:0] disp_ram_addr;
  logic [$bits(ram_addr)-1:0] wr_ram_addr;
  logic [1:0]                tag_q;
  logic [1:0]                sync_q;

  // Scan-out owns every visible pixel slot; the writer takes whatever is left.
  always_comb begin
    slot = IDLE;
    if (pixclk && valid) slot = DISP;
    else if (wr_req)     slot = WR;
  end

`ifdef VRAM_DOUBLE_BUFFER_EN
  logic swap_pending;

  // Display reads the front bank while the writer fills the back bank.
  assign disp_ram_addr = {front_bank, scan_addr(x, y)};
  assign wr_ram_addr   = {~front_bank, wr_addr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap_pending && x == '0 && y == 10'(V_ACTIVE)) begin
      front_bank   <= ~front_bank;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end
`else
  assign disp_ram_addr = scan_addr(x, y);
  assign wr_ram_addr   = wr_addr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      wr_ack    <= 1'b0;
    end else begin
      case (slot)
        DISP: begin
          ram_addr <= disp_ram_addr;
          ram_we   <= 1'b0;
          wr_ack   <= 1'b0;
        end
        WR: begin
          ram_addr  <= wr_ram_addr;
          ram_wdata <= wr_data;
          ram_we    <= (wr_addr < FB_LIMIT);
          wr_ack    <= 1'b1;
        end
        default: begin
          ram_we <= 1'b0;
          wr_ack <= 1'b0;
        end
      endcase
    end
  end

  // Tag bit 1 marks a pixel slot, bit 0 marks it as visible (a real read).
  vram_delay_line #(.WIDTH(2), .DEPTH(2), .RST_VAL(2'b00)) u_tag_dly (
    .clk (clk),
    .rst (rst),
    .d   ({pixclk, pixclk & valid}),
    .q   (tag_q)
  );

  vram_delay_line #(.WIDTH(2), .DEPTH(3), .RST_VAL(2'b11)) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .d   ({hsync_in, vsync_in}),
    .q   (sync_q)
  );

  assign hsync_out = sync_q[1];
  assign vsync_out = sync_q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_out <= '0;
    end else if (tag_q[1]) begin
      pix_out <= tag_q[0] ? ram_rdata : '0;
    end
  end

endmodule
